cdb_arbiter: RTL

//   Collects completed results from NUM_FU functional units (one 1-entry holding slot each),

---
 rtl/cdb_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common data bus arbiter.
//   Each FU owns a 1-entry holding slot. Every cycle one eligible slot is picked round-robin
//   and its result is registered onto the CDB. Branch-mispredict flushes kill held and
//   incoming results that are younger than the flush boundary (ages are relative to the ROB head).
// Ports:
//   i_clk, i_rst                   clock, synchronous active-high reset
//   i_fu_valid/tag/value/exc       per-FU result inputs (tag/value packed, FU i at [i*W +: W])
//   o_fu_ready                     per-FU slot can accept this cycle
//   o_cdb_valid/tag/value/exc      registered broadcast
//   o_cdb_fu_id                    source FU of the broadcast
//   i_flush_en, i_flush_tag        partial flush: kill tags younger than i_flush_tag
//   i_rob_head_tag                 age reference
//   i_flush_all                    kill everything
//   o_pending                      number of occupied slots
module cdb_arbiter #(
  parameter int unsigned NUM_FU = 4,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned DATA_W = 64,
  localparam int unsigned IdW   = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
  localparam int unsigned CntW  = $clog2(NUM_FU + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_FU-1:0]        i_fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]  i_fu_tag,
  input  logic [NUM_FU*DATA_W-1:0] i_fu_value,
  input  logic [NUM_FU-1:0]        i_fu_exc,
  output logic [NUM_FU-1:0]        o_fu_ready,
  output logic                     o_cdb_valid,
  output logic [TAG_W-1:0]         o_cdb_tag,
  output logic [DATA_W-1:0]        o_cdb_value,
  output logic                     o_cdb_exc,
  output logic [IdW-1:0]           o_cdb_fu_id,
  input  logic                     i_flush_en,
  input  logic [TAG_W-1:0]         i_flush_tag,
  input  logic [TAG_W-1:0]         i_rob_head_tag,
  input  logic                     i_flush_all,
  output logic [CntW-1:0]          o_pending
);

  logic [NUM_FU-1:0]             slot_v_q, slot_v_d;
  logic [NUM_FU-1:0][TAG_W-1:0]  slot_tag_q, slot_tag_d;
  logic [NUM_FU-1:0][DATA_W-1:0] slot_value_q, slot_value_d;
  logic [NUM_FU-1:0]             slot_exc_q, slot_exc_d;
  logic [IdW-1:0]                rr_q, rr_d;
  logic                          cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]              cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0]             cdb_value_q, cdb_value_d;
  logic                          cdb_exc_q, cdb_exc_d;
  logic [IdW-1:0]                cdb_fu_id_q, cdb_fu_id_d;

  logic [NUM_FU-1:0] slot_kill, in_kill, eligible, grant, accept;
  logic [IdW-1:0]    winner;
  logic              win_found;
  int unsigned       arb_idx;
  logic [CntW-1:0]   pending;

  // Ages are distances from the ROB head modulo 2^TAG_W, so wrap-around compares correctly.
  function automatic logic kill_f(input logic [TAG_W-1:0] tag, input logic [TAG_W-1:0] head,
                                  input logic [TAG_W-1:0] ftag, input logic en,
                                  input logic all);
    logic [TAG_W-1:0] age;
    logic [TAG_W-1:0] bound;
    age   = tag - head;
    bound = ftag - head;
    return all | (en & (age > bound));
  endfunction

  always_comb begin
    slot_kill = '0;
    in_kill   = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      slot_kill[i] = kill_f(slot_tag_q[i], i_rob_head_tag, i_flush_tag, i_flush_en, i_flush_all);
      in_kill[i]   = kill_f(i_fu_tag[i*TAG_W +: TAG_W], i_rob_head_tag, i_flush_tag, i_flush_en,
                            i_flush_all);
    end
    eligible = slot_v_q & ~slot_kill;
  end

  // Round-robin: first eligible index at or after rr_q, wrapping.
  always_comb begin
    grant     = '0;
    winner    = '0;
    win_found = 1'b0;
    arb_idx   = 0;
    for (int unsigned k = 0; k < NUM_FU; k++) begin
      arb_idx = (32'(rr_q) + k) % NUM_FU;
      if (!win_found && eligible[arb_idx]) begin
        win_found        = 1'b1;
        winner           = IdW'(arb_idx);
        grant[arb_idx]   = 1'b1;
      end
    end
  end

  assign o_fu_ready = ~slot_v_q | grant;
  assign accept     = i_fu_valid & o_fu_ready;

  always_comb begin
    slot_v_d     = slot_v_q;
    slot_tag_d   = slot_tag_q;
    slot_value_d = slot_value_q;
    slot_exc_d   = slot_exc_q;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (accept[i] && !in_kill[i]) begin
        // Refill wins over the same-cycle grant of the old entry.
        slot_v_d[i]     = 1'b1;
        slot_tag_d[i]   = i_fu_tag[i*TAG_W +: TAG_W];
        slot_value_d[i] = i_fu_value[i*DATA_W +: DATA_W];
        slot_exc_d[i]   = i_fu_exc[i];
      end else if (grant[i] || slot_kill[i]) begin
        slot_v_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    cdb_valid_d = win_found;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;
    cdb_exc_d   = cdb_exc_q;
    cdb_fu_id_d = cdb_fu_id_q;
    rr_d        = rr_q;
    if (win_found) begin
      cdb_tag_d   = slot_tag_q[winner];
      cdb_value_d = slot_value_q[winner];
      cdb_exc_d   = slot_exc_q[winner];
      cdb_fu_id_d = winner;
      rr_d        = IdW'((32'(winner) + 1) % NUM_FU);
    end
  end

  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      pending = pending + CntW'(slot_v_q[i]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      slot_v_q     <= '0;
      slot_tag_q   <= '0;
      slot_value_q <= '0;
      slot_exc_q   <= '0;
      rr_q         <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_value_q  <= '0;
      cdb_exc_q    <= 1'b0;
      cdb_fu_id_q  <= '0;
    end else begin
      slot_v_q     <= slot_v_d;
      slot_tag_q   <= slot_tag_d;
      slot_value_q <= slot_value_d;
      slot_exc_q   <= slot_exc_d;
      rr_q         <= rr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_value_q  <= cdb_value_d;
      cdb_exc_q    <= cdb_exc_d;
      cdb_fu_id_q  <= cdb_fu_id_d;
    end
  end

  assign o_cdb_valid = cdb_valid_q;
  assign o_cdb_tag   = cdb_tag_q;
  assign o_cdb_value = cdb_value_q;
  assign o_cdb_exc   = cdb_exc_q;
  assign o_cdb_fu_id = cdb_fu_id_q;
  assign o_pending   = pending;

endmodule
